// File: rtl/param_memory.sv
// param_memory: byte-enabled 1W/1R synchronous RAM with a post-reset clear sweep.
// Ports: clk, reset (async, active-high), cen, wen, wr_addr, ben, din, ren,
//   rd_addr -> dout (registered, latency 1), dout_valid, busy (sweep running).
// Macro PARAM_MEMORY_BYPASS_EN: same-address read/write returns the merged
//   new word; when undefined the read returns the old word (read-first).
module param_memory #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cen,
   input  logic                wen,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W/8-1:0] ben,
   input  logic [DATA_W-1:0]   din,
   input  logic                ren,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   dout,
   output logic                dout_valid,
   output logic                busy
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic [ADDR_W-1:0]   w_clr_cnt_nxt;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_run;
   logic                w_clr_en;
   logic                w_wr_en;
   logic                w_collide;
   logic [DATA_W-1:0]   w_old_wr;
   logic [DATA_W-1:0]   w_merged;
   logic [DATA_W-1:0]   w_rd_word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      unique case (r_state)
         S_CLEAR: begin
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST_ADDR) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   assign busy  = (r_state == S_CLEAR);
   assign w_run = (r_state == S_RUN);

   // Hold the sweep off while reset is still high so word 0 is
   // written on the first edge after release, not during reset.
   assign w_clr_en = busy && !reset;
   assign w_wr_en  = w_run && cen && wen;

   always_comb begin
      w_old_wr = r_mem[wr_addr];
      w_merged = w_old_wr;
      for (int k = 0; k < NB; k++) begin
         if (ben[k]) begin
            w_merged[8*k +: 8] = din[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_clr_en) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_en) begin
         r_mem[wr_addr] <= w_merged;
      end
   end

`ifdef PARAM_MEMORY_BYPASS_EN
   assign w_collide = w_wr_en && (wr_addr == rd_addr);
`else
   assign w_collide = 1'b0;
`endif

   // With ben=0 the merged word equals the old word, so the bypass
   // needs no separate byte-enable qualification.
   assign w_rd_word = w_collide ? w_merged : r_mem[rd_addr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (!w_run) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (!cen) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (ren) begin
         dout       <= w_rd_word;
         dout_valid <= 1'b1;
      end else begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_memory.sv
// tb_param_memory: vector table, hand sequences and random traffic
// for param_memory, checked against a behavioural array model.
module tb_param_memory;

   localparam int DEPTH = 32;

`ifdef PARAM_MEMORY_BYPASS_EN
   localparam logic [31:0] COLL = 32'h12345678;
`else
   localparam logic [31:0] COLL = 32'h00000001;
`endif

   logic        clk;
   logic        reset;
   logic        cen;
   logic        wen;
   logic [4:0]  wr_addr;
   logic [3:0]  ben;
   logic [31:0] din;
   logic        ren;
   logic [4:0]  rd_addr;
   logic [31:0] dout;
   logic        dout_valid;
   logic        busy;

   param_memory #(
      .DATA_W(32),
      .ADDR_W(5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cen       (cen),
      .wen       (wen),
      .wr_addr   (wr_addr),
      .ben       (ben),
      .din       (din),
      .ren       (ren),
      .rd_addr   (rd_addr),
      .dout      (dout),
      .dout_valid(dout_valid),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_dout;
   logic        m_valid;
   int          m_left;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++)
         if (be[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   task automatic model_edge();
      logic [31:0] old;
      if (reset) return;
      if (m_left > 0) begin
         m_mem[DEPTH - m_left] = 32'h0;
         m_left--;
         m_dout  = 32'h0;
         m_valid = 1'b0;
      end else if (!cen) begin
         m_dout  = 32'h0;
         m_valid = 1'b0;
      end else begin
         old = m_mem[rd_addr];
`ifdef PARAM_MEMORY_BYPASS_EN
         if (wen && wr_addr == rd_addr)
            old = merge(m_mem[wr_addr], din, ben);
`endif
         m_valid = ren;
         if (ren) m_dout = old;
         if (wen) m_mem[wr_addr] = merge(m_mem[wr_addr], din, ben);
      end
   endtask

   task automatic cyc(input logic c, input logic w, input logic [4:0] wa,
                      input logic [3:0] be, input logic [31:0] d,
                      input logic r, input logic [4:0] ra);
      cen = c; wen = w; wr_addr = wa; ben = be; din = d;
      ren = r; rd_addr = ra;
      @(posedge clk);
      model_edge();
      #1;
      chk("busy", {31'b0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
      chk("dout", dout, m_dout);
      chk("dout_valid", {31'b0, dout_valid}, {31'b0, m_valid});
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0);
   endtask

   task automatic assert_rst();
      reset   = 1'b1;
      m_left  = DEPTH;
      m_dout  = 32'h0;
      m_valid = 1'b0;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd1);
      chk("rst_dout", dout, 32'h0);
      chk("rst_valid", {31'b0, dout_valid}, 32'd0);
   endtask

   task automatic sweep_len(input string nm, input logic hold_req);
      int k;
      k = 0;
      do begin
         if (hold_req)
            cyc(1'b1, 1'b1, 5'd3, 4'hF, 32'hFFFFFFFF, 1'b1, 5'd3);
         else
            idle();
         k++;
      end while (busy && k < 40);
      chk(nm, k, 32);
   endtask

   typedef struct {
      logic        c;
      logic        w;
      logic [4:0]  wa;
      logic [3:0]  be;
      logic [31:0] d;
      logic        r;
      logic [4:0]  ra;
      logic        cd;
      logic [31:0] ed;
      logic        ev;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      cen = 0; wen = 0; wr_addr = 0; ben = 0; din = 0;
      ren = 0; rd_addr = 0; reset = 0;

      // power-on reset and first sweep
      assert_rst();
      idle();
      idle();
      reset = 1'b0;
      sweep_len("sweep0_len", 1'b0);

      tbl[0]  = '{1, 1, 7,  4'hF, 32'h11223344, 0, 0,  0, 0, 0};
      tbl[1]  = '{1, 1, 7,  4'h5, 32'hAABBCCDD, 0, 0,  0, 0, 0};
      tbl[2]  = '{1, 0, 0,  4'h0, 32'h0,        1, 7,  1, 32'h11BB33DD, 1};
      tbl[3]  = '{1, 1, 9,  4'hF, 32'h00000001, 0, 0,  1, 32'h11BB33DD, 0};
      tbl[4]  = '{1, 1, 9,  4'hF, 32'h12345678, 1, 9,  1, COLL, 1};
      tbl[5]  = '{1, 0, 0,  4'h0, 32'h0,        1, 9,  1, 32'h12345678, 1};
      tbl[6]  = '{0, 1, 2,  4'hF, 32'hFFFFFFFF, 1, 2,  1, 32'h0, 0};
      tbl[7]  = '{1, 0, 0,  4'h0, 32'h0,        1, 2,  1, 32'h0, 1};
      tbl[8]  = '{1, 1, 31, 4'hF, 32'hA5A5A5A5, 0, 0,  1, 32'h0, 0};
      tbl[9]  = '{1, 0, 0,  4'h0, 32'h0,        1, 31, 1, 32'hA5A5A5A5, 1};
      tbl[10] = '{1, 0, 0,  4'h0, 32'h0,        0, 0,  1, 32'hA5A5A5A5, 0};
      tbl[11] = '{1, 0, 0,  4'h0, 32'h0,        0, 0,  1, 32'hA5A5A5A5, 0};
      tbl[12] = '{1, 1, 31, 4'h0, 32'h5A5A5A5A, 1, 31, 1, 32'hA5A5A5A5, 1};
      tbl[13] = '{1, 0, 0,  4'h0, 32'h0,        1, 31, 1, 32'hA5A5A5A5, 1};

      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].c, tbl[i].w, tbl[i].wa, tbl[i].be, tbl[i].d,
             tbl[i].r, tbl[i].ra);
         if (tbl[i].cd)
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].ed);
         chk($sformatf("tbl%0d_valid", i), {31'b0, dout_valid},
             {31'b0, tbl[i].ev});
      end

      // preload then reset sweep with requests held
      cyc(1, 1, 5'd3, 4'hF, 32'hDEADBEEF, 0, 0);
      cyc(1, 0, 5'd0, 4'h0, 32'h0, 1, 5'd3);
      chk("preload", dout, 32'hDEADBEEF);
      assert_rst();
      cyc(1, 1, 5'd3, 4'hF, 32'hFFFFFFFF, 1, 5'd3);
      reset = 1'b0;
      sweep_len("sweep_hold_len", 1'b1);
      cyc(1, 0, 5'd0, 4'h0, 32'h0, 1, 5'd3);
      chk("clr_addr3", dout, 32'h0);
      chk("clr_addr3_v", {31'b0, dout_valid}, 32'd1);

      // reset mid-sweep at clr_cnt=10
      assert_rst();
      idle();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) idle();
      assert_rst();
      idle();
      reset = 1'b0;
      sweep_len("sweep_restart_len", 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) != 0), $urandom_range(0, 1),
             5'($urandom_range(0, 7)), 4'($urandom),
             $urandom, $urandom_range(0, 1),
             5'($urandom_range(0, 7)));
      end
      for (int a = 0; a < DEPTH; a++)
         cyc(1, 0, 5'd0, 4'h0, 32'h0, 1, 5'(a));

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port cen, input, 1 bit, chip enable gating both ports.
REQ-006 The block SHALL have port wen, input, 1 bit, write request.
REQ-007 The block SHALL have port wr_addr, input, ADDR_W bits, write address.
REQ-008 The block SHALL have port ben, input, DATA_W/8 bits, byte write enables; bit k covers din[8k+7:8k].
REQ-009 The block SHALL have port din, input, DATA_W bits, write data.
REQ-010 The block SHALL have port ren, input, 1 bit, read request.
REQ-011 The block SHALL have port rd_addr, input, ADDR_W bits, read address.
REQ-012 The block SHALL have port dout, output, DATA_W bits, registered read data.
REQ-013 The block SHALL have port dout_valid, output, 1 bit, high for one cycle when dout carries fresh read data.
REQ-014 The block SHALL have port busy, output, 1 bit, high while the clear sweep runs.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR, the block SHALL write zero to word clr_cnt each cycle, with clr_cnt counting 0 to DEPTH-1, and SHALL enter RUN on the cycle after writing DEPTH-1.
REQ-017 busy SHALL be 1 in CLEAR and 0 in RUN; the sweep SHALL take exactly DEPTH cycles after reset deassertion.
REQ-018 In CLEAR, cen, wen and ren SHALL be ignored; dout SHALL be 0 and dout_valid SHALL be 0.
REQ-019 In RUN with cen=1 and wen=1, the block SHALL write at the clock edge only the bytes of din selected by ben into mem[wr_addr]; when ben=0, no change SHALL occur.
REQ-020 In RUN with cen=1 and ren=1, the block SHALL present mem[rd_addr] on dout one cycle later (latency 1) with dout_valid=1 in that cycle.
REQ-021 The write and read ports SHALL operate in the same cycle independently.
REQ-022 In RUN with cen=1 and ren=0, dout SHALL hold its last value and dout_valid SHALL be 0.
REQ-023 In RUN with cen=0, the block SHALL perform no write, SHALL set dout to 0 at the next edge, and SHALL hold dout_valid at 0.
REQ-024 A same-cycle read and write to the same address SHALL follow REQ-036 and REQ-037.
REQ-025 Addresses SHALL wrap naturally within ADDR_W bits; no out-of-range condition exists.

Reset
REQ-026 Asserting reset SHALL immediately force state to CLEAR, clr_cnt to 0, dout to 0, dout_valid to 0 and busy to 1.
REQ-027 Reset SHALL NOT asynchronously clear the memory array; the array SHALL be cleared only by the sweep.
REQ-028 Reset asserted mid-sweep or mid-operation SHALL abort any pending access and SHALL restart the sweep from address 0.
REQ-029 The sweep SHALL begin on the first rising clk edge after reset deasserts.

Configuration
REQ-030 Macro PARAM_MEMORY_BYPASS_EN SHALL select read-during-write behaviour for same-address collisions.
REQ-031 (REQ-030 detail) The macro SHALL NOT change ports or latency.
REQ-036 With PARAM_MEMORY_BYPASS_EN defined, a same-address collision SHALL return the write-merged word: din bytes where ben=1, old bytes elsewhere.
REQ-037 Without PARAM_MEMORY_BYPASS_EN, a same-address collision SHALL return the old word (read-first).

Verification
REQ-032 The bench SHALL cover clear sweep: preload mem[3] with 0xDEADBEEF, pulse reset, hold requests -> busy=1 for exactly 32 cycles, then read addr 3 -> dout=0x00000000 with dout_valid=1 one cycle later.
REQ-033 The bench SHALL cover byte enables: write 0x11223344 ben=1111 to addr 7, then 0xAABBCCDD ben=0101 -> read addr 7 returns 0x11BB33DD.
REQ-034 The bench SHALL cover collision: mem[9]=0x00000001; same cycle write 0x12345678 ben=1111 and read addr 9 -> dout=0x12345678 with the macro, 0x00000001 without; next read -> 0x12345678.
REQ-035 The bench SHALL cover cen gating: cen=0 with wen=1 to addr 2, data 0xFFFFFFFF -> dout=0 next cycle, dout_valid=0, later read addr 2 returns 0.
REQ-038 The bench SHALL cover reset mid-sweep: assert reset at clr_cnt=10 -> busy stays 1, sweep restarts at 0 and completes 32 cycles after deassertion.
REQ-039 The bench SHALL cover wrap and hold: read addr 31 then idle with ren=0, cen=1 -> dout holds mem[31], dout_valid pulses exactly once.
